// File: rtl/row_window_mem.sv
// Banked row store that returns an N_BANKS-row window centred on a requested row.
// Row r lives in bank (r mod N_BANKS); all banks are read in parallel for one window.
module row_window_mem #(
  parameter int unsigned N_BANKS  = 3,
  parameter int unsigned ROW_W    = 256,
  parameter int unsigned MAX_ROWS = 256,
  localparam int unsigned ADDR_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
  input  logic                            i_clock,
  input  logic                            i_reset_n,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [ADDR_W-1:0]               i_wr_addr,
  input  logic [ROW_W-1:0]                i_wr_data,
  output logic                            o_wr_err,
  input  logic                            i_rd_req_valid,
  output logic                            o_rd_req_ready,
  input  logic [ADDR_W-1:0]               i_rd_row,
  output logic                            o_rd_valid,
  input  logic                            i_rd_ready,
  output logic [N_BANKS-1:0][ROW_W-1:0]   o_rd_data,
  input  logic                            i_clear,
  output logic                            o_busy
);

  localparam int NB    = int'(N_BANKS);
  localparam int HALF  = (NB - 1) / 2;
  localparam int NROWS = int'(MAX_ROWS);
  localparam int DEPTH = (NROWS + NB - 1) / NB;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_t;

  state_t                          r_state, w_state_d;
  logic [MAX_ROWS-1:0]             r_valid;
  logic [ADDR_W-1:0]               r_rd_row;
  logic [N_BANKS-1:0]              r_win_ok;
  logic [N_BANKS-1:0][ROW_W-1:0]   r_rd_data;
  logic                            r_wr_err;

  logic                            w_clr, w_wr_acc, w_rd_acc, w_wr_do, w_wr_in_range;
  int                              w_wr_bank;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [N_BANKS-1:0]              w_win_ok;
  logic [IDX_W-1:0]                w_rd_idx   [N_BANKS];
  logic [IDX_W-1:0]                w_bank_idx [N_BANKS];
  logic [N_BANKS-1:0]              w_bank_en;
  logic [N_BANKS-1:0][ROW_W-1:0]   w_bank_out;
  logic [N_BANKS-1:0][ROW_W-1:0]   w_win;

  assign o_wr_ready     = (r_state == StIdle) && !i_clear;
  assign o_rd_req_ready = (r_state == StIdle) && !i_clear && !i_wr_valid;
  assign o_rd_valid     = (r_state == StHold);
  assign o_busy         = (r_state != StIdle);
  assign o_rd_data      = r_rd_data;
  assign o_wr_err       = r_wr_err;

  assign w_wr_in_range = ({1'b0, i_wr_addr} < (ADDR_W + 1)'(MAX_ROWS));
  assign w_wr_do       = w_wr_acc && w_wr_in_range;

  // Priority in idle: clear > write > read.
  always_comb begin
    w_state_d = r_state;
    w_clr     = 1'b0;
    w_wr_acc  = 1'b0;
    w_rd_acc  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_clear) begin
          w_clr = 1'b1;
        end else if (i_wr_valid) begin
          w_wr_acc = 1'b1;
        end else if (i_rd_req_valid) begin
          w_rd_acc  = 1'b1;
          w_state_d = StFetch;
        end
      end
      StFetch: w_state_d = StHold;
      StHold:  if (i_rd_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Per-bank read index and per-window-slot validity, evaluated at request acceptance.
  always_comb begin : p_rd_map
    int v_row;
    w_win_ok = '0;
    for (int b = 0; b < NB; b++) w_rd_idx[b] = '0;
    for (int k = 0; k < NB; k++) begin
      v_row = int'(i_rd_row) - HALF + k;
      if (v_row >= 0 && v_row < NROWS) begin
        w_win_ok[k] = r_valid[ADDR_W'(v_row)];
        for (int b = 0; b < NB; b++) begin
          if (v_row % NB == b) w_rd_idx[b] = IDX_W'(v_row / NB);
        end
      end
    end
  end

  always_comb begin
    w_wr_bank = int'(i_wr_addr) % NB;
    w_wr_idx  = IDX_W'(int'(i_wr_addr) / NB);
    for (int b = 0; b < NB; b++) begin
      w_bank_en[b]  = w_rd_acc || (w_wr_do && (w_wr_bank == b));
      w_bank_idx[b] = w_wr_do ? w_wr_idx : w_rd_idx[b];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic [ROW_W-1:0] r_mem [DEPTH];
    logic [ROW_W-1:0] r_rdata;
    always_ff @(posedge i_clock) begin
      if (w_bank_en[g]) begin
        if (w_wr_do) r_mem[w_bank_idx[g]] <= i_wr_data;
        else         r_rdata <= r_mem[w_bank_idx[g]];
      end
    end
    assign w_bank_out[g] = r_rdata;
  end

  // Rotate bank outputs into window order; +NB keeps the modulo non-negative.
  always_comb begin : p_rotate
    int v_row;
    w_win = '0;
    for (int k = 0; k < NB; k++) begin
      v_row = int'(r_rd_row) - HALF + k + NB;
      for (int b = 0; b < NB; b++) begin
        if ((v_row % NB == b) && r_win_ok[k]) w_win[k] = w_bank_out[b];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_valid   <= '0;
      r_rd_row  <= '0;
      r_win_ok  <= '0;
      r_rd_data <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_wr_err <= w_wr_acc && !w_wr_in_range;
      if (w_clr)        r_valid <= '0;
      else if (w_wr_do) r_valid[i_wr_addr] <= 1'b1;
      if (w_rd_acc) begin
        r_rd_row <= i_rd_row;
        r_win_ok <= w_win_ok;
      end
      if (r_state == StFetch) r_rd_data <= w_win;
    end
  end

endmodule

// File: tb/tb_row_window_mem.sv
// Scoreboarded bench for row_window_mem with 3 banks, 8-bit rows and 8 rows.
module tb_row_window_mem;

  localparam int unsigned NB = 3;
  localparam int unsigned RW = 8;
  localparam int unsigned MR = 8;
  localparam int unsigned AW = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     wr_valid = 1'b0, wr_ready, wr_err;
  logic [AW-1:0]            wr_addr = '0;
  logic [RW-1:0]            wr_data = '0;
  logic                     rd_req_valid = 1'b0, rd_req_ready;
  logic [AW-1:0]            rd_row = '0;
  logic                     rd_valid, rd_ready = 1'b0;
  logic [NB-1:0][RW-1:0]    rd_data;
  logic                     clear = 1'b0, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] sb_q[$];

  always #5 clk = ~clk;

  row_window_mem #(.N_BANKS(NB), .ROW_W(RW), .MAX_ROWS(MR)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .o_wr_err       (wr_err),
    .i_rd_req_valid (rd_req_valid),
    .o_rd_req_ready (rd_req_ready),
    .i_rd_row       (rd_row),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_rd_data      (rd_data),
    .i_clear        (clear),
    .o_busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Window slot k holds row (centre - 1 + k); slot 0 is the low byte.
  function automatic logic [23:0] win(input logic [7:0] a0, input logic [7:0] a1,
                                      input logic [7:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completed window handshakes are scored against the queue.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected", 32'(rd_data), 32'hDEAD);
      else                  check_eq("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
    end
  end

  task automatic write_row(input logic [AW-1:0] a, input logic [RW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    check_eq("wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check_eq("wr_err", 32'(wr_err), 32'd0);
  endtask

  task automatic read_win(input logic [AW-1:0] row, input logic [23:0] exp, input int hold);
    int waited;
    sb_q.push_back(exp);
    rd_req_valid = 1'b1;
    rd_row       = row;
    waited       = 0;
    @(negedge clk);
    while (!rd_req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rd_req_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    check_eq("lat_fetch_valid", 32'(rd_valid), 32'd0);
    check_eq("lat_fetch_busy", 32'(busy), 32'd1);
    tick();
    check_eq("lat_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_data", 32'(rd_data), 32'(exp));
      check_eq("hold_req_ready", 32'(rd_req_ready), 32'd0);
      check_eq("hold_busy", 32'(busy), 32'd1);
      tick();
      check_eq("hold_valid", 32'(rd_valid), 32'd1);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("post_valid", 32'(rd_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_rd_req_ready", 32'(rd_req_ready), 32'd1);
    check_eq("rst_wr_err", 32'(wr_err), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 8; r++) write_row(AW'(r), RW'(8'h10 + r));
    read_win(3'd4, win(8'h13, 8'h14, 8'h15), 0);
    read_win(3'd0, win(8'h00, 8'h10, 8'h11), 0);
    read_win(3'd7, win(8'h16, 8'h17, 8'h00), 0);
    read_win(3'd1, win(8'h10, 8'h11, 8'h12), 5);

    // Clear blocks both ready outputs while it is high.
    clear = 1'b1;
    @(negedge clk);
    check_eq("clr_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("clr_rd_req_ready", 32'(rd_req_ready), 32'd0);
    tick();
    clear = 1'b0;
    write_row(3'd2, 8'hAA);
    read_win(3'd2, win(8'h00, 8'hAA, 8'h00), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    read_win(3'd2, win(8'h00, 8'h00, 8'h00), 0);

    // Clear beats a simultaneous write and read; then write beats read.
    write_row(3'd4, 8'h44);
    clear        = 1'b1;
    wr_valid     = 1'b1;
    wr_addr      = 3'd3;
    wr_data      = 8'h5C;
    rd_req_valid = 1'b1;
    rd_row       = 3'd3;
    @(negedge clk);
    check_eq("prio_clr_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("prio_clr_rd_ready", 32'(rd_req_ready), 32'd0);
    tick();
    clear = 1'b0;
    check_eq("prio_clr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("prio_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("prio_rd_ready", 32'(rd_req_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    check_eq("prio_busy", 32'(busy), 32'd0);
    read_win(3'd3, win(8'h00, 8'h5C, 8'h00), 0);

    // Reset during FETCH abandons the read and invalidates stored rows.
    write_row(3'd5, 8'h55);
    rd_req_valid = 1'b1;
    rd_row       = 3'd5;
    @(negedge clk);
    check_eq("abort_req_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rd_data", 32'(rd_data), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("after_rst_valid0", 32'(rd_valid), 32'd0);
    tick();
    check_eq("after_rst_valid1", 32'(rd_valid), 32'd0);
    check_eq("after_rst_busy", 32'(busy), 32'd0);
    read_win(3'd5, win(8'h00, 8'h00, 8'h00), 0);
    read_win(3'd4, win(8'h00, 8'h00, 8'h00), 0);

    repeat (2) tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/row_window_mem.md
ROW_WINDOW_MEM -- requirements
Module: row_window_mem

Interface
REQ-001 SHALL have parameter N_BANKS, default 3: bank count and window height; odd, >= 3.
REQ-002 SHALL have parameter ROW_W, default 256: bits per row.
REQ-003 SHALL have parameter MAX_ROWS, default 256: row capacity; ADDR_W = clog2(MAX_ROWS); HALF = (N_BANKS-1)/2.
REQ-004 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low.
REQ-006 SHALL have port wr_valid, input, 1: write request.
REQ-007 SHALL have port wr_ready, output, 1: write accepted when wr_valid && wr_ready.
REQ-008 SHALL have port wr_addr, input, ADDR_W: destination row.
REQ-009 SHALL have port wr_data, input, ROW_W: row contents.
REQ-010 SHALL have port wr_err, output, 1: one-cycle pulse when an accepted write has wr_addr >= MAX_ROWS.
REQ-011 SHALL have port rd_req_valid, input, 1: window read request.
REQ-012 SHALL have port rd_req_ready, output, 1: read request accepted when both high.
REQ-013 SHALL have port rd_row, input, ADDR_W: centre row of window.
REQ-014 SHALL have port rd_valid, output, 1: window data valid.
REQ-015 SHALL have port rd_ready, input, 1: consumer accepts window.
REQ-016 SHALL have port rd_data, output, N_BANKS x ROW_W: rd_data[k] = row (rd_row - HALF + k).
REQ-017 SHALL have port clear, input, 1: invalidate all rows.
REQ-018 SHALL have port busy, output, 1: high whenever state != IDLE.

Function
REQ-019 SHALL store row r in bank (r mod N_BANKS) at index (r / N_BANKS); each bank is a single-port synchronous RAM of depth ceil(MAX_ROWS/N_BANKS) with 1-cycle read latency.
REQ-020 SHALL keep a MAX_ROWS-bit valid vector; bit r set on accepted in-range write to r, all bits cleared by clear.
REQ-021 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-022 SHALL, in IDLE, apply priority clear > write > read: wr_ready = IDLE && !clear; rd_req_ready = IDLE && !clear && !wr_valid.
REQ-023 SHALL complete clear in the cycle it is sampled in IDLE; clear outside IDLE is ignored.
REQ-024 SHALL complete an accepted write in one cycle, remaining in IDLE; out-of-range write leaves memory and valid vector unchanged and pulses wr_err next cycle.
REQ-025 SHALL, on accepted read, register rd_row, enable all N_BANKS banks in parallel with per-bank index for the window row mapped to that bank, and go to FETCH.
REQ-026 SHALL, in FETCH, rotate bank outputs by (rd_row - HALF) mod N_BANKS into window order, register into rd_data, assert rd_valid, go to HOLD; read latency = 2 cycles from acceptance to rd_valid.
REQ-027 SHALL return all-zero for any window row that is negative (rd_row < HALF underflow), >= MAX_ROWS, or not valid.
REQ-028 SHALL hold rd_data and rd_valid stable in HOLD until rd_ready; on rd_valid && rd_ready deassert rd_valid and return to IDLE next cycle.
REQ-029 SHALL allow one outstanding read only; no new request accepted before handshake completes.
REQ-030 SHALL show a write accepted in cycle T to a read accepted in cycle T+1 or later.

Reset
REQ-031 SHALL, while reset low, force state IDLE, valid vector zero, rd_valid 0, rd_data zero, wr_err 0, busy 0; wr_ready and rd_req_ready follow REQ-022 from IDLE.
REQ-032 SHALL abandon any in-flight read on reset assertion; RAM contents undefined but masked by cleared valid vector.

Verification (N_BANKS=3, ROW_W=8, MAX_ROWS=8)
REQ-033 SHALL cover: write rows 0..7 = 0x10+r, read rd_row=4 -> rd_valid 2 cycles after accept, rd_data = {0x13,0x14,0x15}.
REQ-034 SHALL cover: read rd_row=0 and rd_row=7 after full fill -> {0x00,0x10,0x11} and {0x16,0x17,0x00}.
REQ-035 SHALL cover: write only row 2 = 0xAA, read rd_row=2 -> {0x00,0xAA,0x00}; then clear, read rd_row=2 -> all zero.
REQ-036 SHALL cover: rd_ready held low 5 cycles after rd_valid -> rd_data stable, rd_req_ready 0, busy 1; released -> IDLE next cycle.
REQ-037 SHALL cover: wr_valid and rd_req_valid same cycle to row 3 -> write accepted first, subsequent read centre = new value; clear also asserted -> clear wins, neither accepted.
REQ-038 SHALL cover: reset pulsed low during FETCH -> rd_valid stays 0, subsequent read of previously written row returns zero.
